// File: rtl/tx_fifo_feeder.sv
// -----------------------------------------------------------------------------
// tx_fifo_feeder
// Byte FIFO that feeds a serial transmitter one frame at a time. Bytes are
// queued in a circular buffer; a small FSM pops the oldest byte, issues a
// one-cycle launch pulse, then waits for the transmitter to accept the frame
// (iTx_Busy) and to finish it (iTx_Done) before launching the next one.
//
// Ports
//   iClk        system clock, rising-edge active
//   iRst_n      asynchronous active-low reset
//   iPush       write request, one byte per cycle while high
//   iPush_Data  byte to enqueue
//   iTx_Busy    transmitter busy (frame accepted, not yet idle)
//   iTx_Done    one-cycle pulse at the transmitter's final stop-bit tick
//   oTx_Start   one-cycle launch pulse to the transmitter
//   oTx_Data    byte presented with oTx_Start, held until the next launch
//   oFull       registered, occupancy == DEPTH
//   oEmpty      registered, occupancy == 0
//   oCount      registered occupancy, 0..DEPTH
//   oOverflow   one-cycle pulse after a push was dropped on a full FIFO
// -----------------------------------------------------------------------------
module tx_fifo_feeder #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          iClk,
    input  logic          iRst_n,
    input  logic          iPush,
    input  logic [7:0]    iPush_Data,
    input  logic          iTx_Busy,
    input  logic          iTx_Done,
    output logic          oTx_Start,
    output logic [7:0]    oTx_Data,
    output logic          oFull,
    output logic          oEmpty,
    output logic [AW:0]   oCount,
    output logic          oOverflow
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;
    logic [AW:0]   countNext;
    logic          isFull;
    logic          doPush;
    logic          doPop;

    // Both decisions use the pre-edge count, so a byte written on this edge
    // can never be popped on the same edge, and a full FIFO drops the push
    // even when a pop happens alongside it.
    assign isFull = (count == DEPTH_C);
    assign doPush = iPush && !isFull;
    assign doPop  = (state == IDLE) && (count != '0);

    always_comb begin
        countNext = count;
        if (doPush && !doPop) begin
            countNext = count + CNT_ONE;
        end else if (!doPush && doPop) begin
            countNext = count - CNT_ONE;
        end
    end

    // Storage has no reset; stale contents are unreachable once count is 0.
    always_ff @(posedge iClk) begin
        if (doPush) begin
            mem[wrPtr] <= iPush_Data;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= IDLE;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            oFull     <= 1'b0;
            oEmpty    <= 1'b1;
            oCount    <= '0;
            oOverflow <= 1'b0;
            oTx_Start <= 1'b0;
            oTx_Data  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is 2**AW.
            if (doPush) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            count     <= countNext;
            oCount    <= countNext;
            oFull     <= (countNext == DEPTH_C);
            oEmpty    <= (countNext == '0);
            oOverflow <= iPush && isFull;

            case (state)
                IDLE: begin
                    if (doPop) begin
                        oTx_Data  <= mem[rdPtr];
                        rdPtr     <= rdPtr + PTR_ONE;
                        oTx_Start <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    oTx_Start <= 1'b0;
                    state     <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (iTx_Busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (iTx_Done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    oTx_Start <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_fifo_feeder.sv
// -----------------------------------------------------------------------------
// tb_tx_fifo_feeder
// Directed bench for tx_fifo_feeder. Every accepted push queues the expected
// byte in a scoreboard; a monitor pops it whenever oTx_Start is seen and
// compares oTx_Data. A transmitter model answers launches with iTx_Busy and a
// delayed iTx_Done. Occupancy, flags and reset behaviour are checked inline.
// -----------------------------------------------------------------------------
module tb_tx_fifo_feeder;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic          iClk = 1'b0;
    logic          iRst_n;
    logic          iPush;
    logic [7:0]    iPush_Data;
    logic          iTx_Busy;
    logic          iTx_Done;
    logic          oTx_Start;
    logic [7:0]    oTx_Data;
    logic          oFull;
    logic          oEmpty;
    logic [AW:0]   oCount;
    logic          oOverflow;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  expQ[$];
    int unsigned cyc = 0;
    bit          modelEn     = 1'b0;
    bit          modelActive = 1'b0;
    bit          gapCheck    = 1'b0;
    bit          gapArmed    = 1'b0;
    int unsigned txLen       = 20;
    int unsigned doneEdge    = 0;
    bit          prevStart   = 1'b0;

    tx_fifo_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iPush      (iPush),
        .iPush_Data (iPush_Data),
        .iTx_Busy   (iTx_Busy),
        .iTx_Done   (iTx_Done),
        .oTx_Start  (oTx_Start),
        .oTx_Data   (oTx_Data),
        .oFull      (oFull),
        .oEmpty     (oEmpty),
        .oCount     (oCount),
        .oOverflow  (oOverflow)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushByte(input logic [7:0] d, input bit accept);
        iPush      = 1'b1;
        iPush_Data = d;
        if (accept) expQ.push_back(d);
        @(negedge iClk);
        iPush = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int unsigned n = 0;
        while (!(oEmpty && !oTx_Start && !modelActive && expQ.size() == 0) && n < 2000) begin
            @(negedge iClk);
            n++;
        end
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: still %0d bytes pending, expected 0", name, expQ.size());
        end else begin
            check({name, "_count"}, oCount, 0);
        end
    endtask

    // Scoreboard monitor: every launch must carry the oldest expected byte.
    initial begin
        forever begin
            @(negedge iClk);
            if (oTx_Start) begin
                check("start_width", prevStart, 0);
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_launch: got data 0x%0h, expected no launch", oTx_Data);
                end else begin
                    check("launch_data", oTx_Data, expQ.pop_front());
                end
                if (gapCheck && gapArmed) begin
                    check("launch_gap", cyc, doneEdge + 1);
                    gapArmed = 1'b0;
                end
            end
            prevStart = oTx_Start;
        end
    end

    // Transmitter model: busy one cycle after the launch, done txLen later.
    initial begin
        forever begin
            @(negedge iClk);
            if (modelEn && oTx_Start) begin
                modelActive = 1'b1;
                @(negedge iClk);
                iTx_Busy = 1'b1;
                repeat (txLen) @(negedge iClk);
                iTx_Done = 1'b1;
                if (gapCheck) begin
                    doneEdge = cyc + 1;
                    gapArmed = 1'b1;
                end
                @(negedge iClk);
                iTx_Done    = 1'b0;
                iTx_Busy    = 1'b0;
                modelActive = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned expCnt[10] = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 8};

        iRst_n     = 1'b0;
        iPush      = 1'b0;
        iPush_Data = '0;
        iTx_Busy   = 1'b0;
        iTx_Done   = 1'b0;

        // Reset state
        repeat (3) @(negedge iClk);
        check("rst_empty",    oEmpty,    1);
        check("rst_full",     oFull,     0);
        check("rst_count",    oCount,    0);
        check("rst_start",    oTx_Start, 0);
        check("rst_data",     oTx_Data,  0);
        check("rst_overflow", oOverflow, 0);
        iRst_n = 1'b1;
        @(negedge iClk);

        // Single byte, launch latency
        modelEn = 1'b1;
        txLen   = 5;
        pushByte(8'hA5, 1'b1);
        check("single_cnt1",   oCount,    1);
        check("single_nempty", oEmpty,    0);
        check("single_nostart", oTx_Start, 0);
        @(negedge iClk);
        check("single_start", oTx_Start, 1);
        check("single_data",  oTx_Data,  8'hA5);
        check("single_empty", oEmpty,    1);
        @(negedge iClk);
        check("single_pulse_end", oTx_Start, 0);
        waitDrain("single");

        // Ordering with 20-cycle frames, back-to-back launches
        txLen    = 20;
        gapArmed = 1'b0;
        gapCheck = 1'b1;
        pushByte(8'h11, 1'b1);
        pushByte(8'h22, 1'b1);
        pushByte(8'h33, 1'b1);
        check("order_cnt", oCount, 2);
        waitDrain("order");
        gapCheck = 1'b0;
        gapArmed = 1'b0;

        // Full / overflow with the transmitter stalled
        modelEn  = 1'b0;
        iTx_Busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pushByte(8'(i), i < 9);
            check("full_count",    oCount,    expCnt[i]);
            check("full_flag",     oFull,     expCnt[i] == 8);
            check("full_overflow", oOverflow, i == 9);
        end
        @(negedge iClk);
        check("ovf_pulse_end", oOverflow, 0);
        check("ovf_count",     oCount,    8);
        iTx_Busy = 1'b0;
        iTx_Done = 1'b1;
        @(negedge iClk);
        iTx_Done = 1'b0;
        txLen    = 2;
        modelEn  = 1'b1;
        waitDrain("full");

        // Wrap-around: 20 bytes in bursts of 5
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 5; j++) pushByte(8'(8'h40 + b * 5 + j), 1'b1);
            waitDrain("wrap");
        end

        // Simultaneous push and pop at count 3
        modelEn  = 1'b0;
        iTx_Busy = 1'b1;
        for (int i = 0; i < 4; i++) pushByte(8'(8'h60 + i), 1'b1);
        check("simul_pre_cnt", oCount, 3);
        repeat (2) @(negedge iClk);
        iTx_Busy = 1'b0;
        iTx_Done = 1'b1;
        @(negedge iClk);
        iTx_Done   = 1'b0;
        iPush      = 1'b1;
        iPush_Data = 8'h64;
        expQ.push_back(8'h64);
        @(negedge iClk);
        iPush = 1'b0;
        check("simul_cnt",   oCount,    3);
        check("simul_start", oTx_Start, 1);
        check("simul_data",  oTx_Data,  8'h61);
        iTx_Busy = 1'b1;
        repeat (3) @(negedge iClk);
        iTx_Busy = 1'b0;
        iTx_Done = 1'b1;
        @(negedge iClk);
        iTx_Done = 1'b0;
        txLen    = 2;
        modelEn  = 1'b1;
        waitDrain("simul");

        // Reset asserted during WAIT_DONE with 4 bytes queued
        modelEn  = 1'b0;
        iTx_Busy = 1'b1;
        for (int i = 0; i < 5; i++) pushByte(8'(8'h70 + i), 1'b1);
        check("mrst_pre_cnt", oCount, 4);
        repeat (2) @(negedge iClk);
        #2;
        iRst_n = 1'b0;
        #1;
        check("mrst_empty",    oEmpty,    1);
        check("mrst_full",     oFull,     0);
        check("mrst_count",    oCount,    0);
        check("mrst_start",    oTx_Start, 0);
        check("mrst_data",     oTx_Data,  0);
        check("mrst_overflow", oOverflow, 0);
        expQ.delete();
        @(negedge iClk);
        iRst_n   = 1'b1;
        iTx_Busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge iClk);
            check("mrst_quiet", oTx_Start, 0);
        end
        modelEn = 1'b1;
        pushByte(8'h7F, 1'b1);
        waitDrain("mrst_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_fifo_feeder.md
TX_FIFO_FEEDER -- requirements
Module: tx_fifo_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving FIFO entries; legal values are powers of 2, at least 2.
REQ-002 The block SHALL have parameter AW, default 3, giving pointer width; it SHALL equal log2(DEPTH).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 iClk  input  1  system clock; all state updates on the rising edge.
REQ-005 iRst_n  input  1  asynchronous active-low reset.
REQ-006 iPush  input  1  write request; one byte per cycle while high.
REQ-007 iPush_Data  input  8  byte to enqueue.
REQ-008 iTx_Busy  input  1  transmitter busy flag; high from frame acceptance until the transmitter returns to idle.
REQ-009 iTx_Done  input  1  one-cycle pulse at the final stop-bit tick.
REQ-010 oTx_Start  output  1  one-cycle launch pulse to the transmitter.
REQ-011 oTx_Data  output  8  byte presented with oTx_Start.
REQ-012 oFull  output  1  high when count = DEPTH.
REQ-013 oEmpty  output  1  high when count = 0.
REQ-014 oCount  output  AW+1  current occupancy, 0..DEPTH.
REQ-015 oOverflow  output  1  one-cycle pulse when a push is dropped.

Function
REQ-016 Storage SHALL be a circular buffer with AW-bit read and write pointers that wrap from DEPTH-1 to 0, plus an AW+1-bit occupancy counter.
REQ-017 A push with count < DEPTH SHALL write iPush_Data at the write pointer, advance the write pointer and increment count on the same edge.
REQ-018 A push with count = DEPTH SHALL leave memory, pointers and count unchanged and SHALL pulse oOverflow high for exactly the next cycle.
REQ-019 A pop SHALL occur only in state IDLE with count > 0, as sampled before the edge; a byte pushed on the same edge is never popped on that edge.
REQ-020 On a simultaneous push and pop with count = DEPTH, the push SHALL be dropped and oOverflow pulsed.
REQ-021 On a simultaneous push and pop with 0 < count < DEPTH, count SHALL be unchanged and both pointers SHALL advance.
REQ-022 oFull, oEmpty and oCount SHALL be registered values that reflect the post-edge count.
REQ-023 The FSM SHALL have exactly four states: IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-024 IDLE with count > 0: on the edge, load oTx_Data from the read pointer, advance the read pointer, set oTx_Start to 1 and go to LAUNCH.
REQ-025 IDLE with count = 0: hold state.
REQ-026 LAUNCH: clear oTx_Start on the next edge and go to WAIT_BUSY, so oTx_Start is high for exactly one cycle.
REQ-027 WAIT_BUSY: go to WAIT_DONE when iTx_Busy = 1; otherwise hold.
REQ-028 WAIT_DONE: go to IDLE when iTx_Done = 1; otherwise hold.
REQ-029 oTx_Data SHALL hold its value from launch until the next launch.
REQ-030 Latency: for a push sampled at edge k into an empty FIFO with the FSM in IDLE, oTx_Start SHALL be high between edges k+1 and k+2.
REQ-031 Back-to-back frames: after the iTx_Done edge, the next oTx_Start SHALL rise one edge later if count > 0.
REQ-032 The block SHALL never assert oTx_Start while in WAIT_BUSY or WAIT_DONE, so no frame can overwrite one in flight.
REQ-033 oOverflow SHALL be independent of FSM state.

Reset
REQ-034 While iRst_n = 0: FSM in IDLE, both pointers 0, count 0, oEmpty = 1, oFull = 0, oCount = 0, oTx_Start = 0, oTx_Data = 0x00, oOverflow = 0.
REQ-035 Reset asserted mid-frame SHALL discard all queued bytes and any in-flight handshake state immediately; memory contents need not be cleared.
REQ-036 After reset release, the first action SHALL occur on the first rising edge with iRst_n = 1.

Verification
REQ-037 Single byte: push 0xA5 into an empty FIFO, with iTx_Busy rising 1 cycle after oTx_Start -> oTx_Start pulses once with oTx_Data = 0xA5, then oEmpty = 1 and the FSM waits for iTx_Done.
REQ-038 Ordering: push 0x11, 0x22 and 0x33 back-to-back, with a transmitter model returning iTx_Done after 20 cycles -> three oTx_Start pulses in the order 0x11, 0x22, 0x33, each launched one edge after the preceding iTx_Done.
REQ-039 Full/overflow: with iTx_Busy held at 1, push 9 bytes 0x00..0x08 -> oFull = 1 after the 8th push (oCount = 8; the first byte may already be popped, so account for it), the 9th or later extra push pulses oOverflow, and oCount never exceeds 8.
REQ-040 Wrap-around: perform 20 push/launch cycles with DEPTH = 8 -> the data order is preserved across pointer wrap and oCount returns to 0.
REQ-041 Simultaneous push/pop: push a byte on the same edge the FSM pops with oCount = 3 -> oCount stays 3 and the popped byte is the oldest entry.
REQ-042 Reset mid-frame: assert iRst_n = 0 during WAIT_DONE with oCount = 4 -> all outputs take their reset values within the same cycle, and no oTx_Start occurs until a new push.
